line_to_word_bridge: RTL and testbench

LINE_TO_WORD_BRIDGE -- requirements
Module: line_to_word_bridge

---
 rtl/line_to_word_bridge.sv | 178 +++++++++++++++++
 tb/tb_line_to_word_bridge.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_to_word_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_to_word_bridge                                             |
// | Purpose  : Converts one cache-line request from the mux slave port into a  |
// |            burst of word requests to a word-wide memory. A line write      |
// |            becomes WORDS_PER_LINE word writes. A line read becomes         |
// |            WORDS_PER_LINE word reads. The returned words are assembled     |
// |            into one line response.                                         |
// | Ports    : clk, reset             - clock, synchronous active-high reset   |
// |            n2m_request_*          - line request in (address/data/rd/wr)   |
// |            m2n_request_available  - bridge idle, may take a request        |
// |            m2n_response_*         - line read response out                 |
// |            mc_avail_o             - requester can take the response        |
// |            mem_req_*              - word request out (valid/ready)         |
// |            mem_rsp_*              - in-order read word return              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

package line_to_word_bridge_pkg;
  typedef logic [31:0]  address_t;
  typedef logic [511:0] dcache_line_t;
endpackage

module line_to_word_bridge
  import line_to_word_bridge_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = $bits(dcache_line_t) / WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  address_t              n2m_request_address,
  input  dcache_line_t          n2m_request_data,
  input  logic                  n2m_request_read,
  input  logic                  n2m_request_write,
  input  logic                  mc_avail_o,
  output logic                  m2n_request_available,
  output logic                  m2n_response_valid,
  output address_t              m2n_response_address,
  output dcache_line_t          m2n_response_data,
  output logic                  mem_req_valid,
  output logic                  mem_req_write,
  output address_t              mem_req_address,
  output logic [WORD_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_rdata
);

  localparam int c_IDX_W      = $clog2(WORDS_PER_LINE);
  localparam int c_CNT_W      = c_IDX_W + 1;
  localparam int c_LINE_BYTES = WORDS_PER_LINE * WORD_WIDTH / 8;

  localparam logic [c_CNT_W-1:0] c_WORDS     = c_CNT_W'(WORDS_PER_LINE);
  localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(WORDS_PER_LINE - 1);
  localparam address_t           c_LINE_MASK = address_t'(c_LINE_BYTES - 1);
  localparam address_t           c_WORD_BYTES = address_t'(WORD_WIDTH / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              r_state;
  address_t            r_addr;       // captured request address
  dcache_line_t        r_line;       // write line, or read assembly buffer
  logic [c_CNT_W-1:0]  r_issue_cnt;
  logic [c_CNT_W-1:0]  r_recv_cnt;
  address_t            r_rsp_addr;
  dcache_line_t        r_rsp_data;

  logic [c_IDX_W-1:0]  w_issue_idx;
  logic [c_IDX_W-1:0]  w_recv_idx;
  logic                w_issue_fire;
  logic                w_recv_fire;
  address_t            w_line_base;
  dcache_line_t        w_line_next;

  // The counters reach WORDS_PER_LINE only after the last word, when the
  // slot index is no longer used, so the low bits are a safe slot index.
  assign w_issue_idx  = r_issue_cnt[c_IDX_W-1:0];
  assign w_recv_idx   = r_recv_cnt[c_IDX_W-1:0];
  assign w_issue_fire = mem_req_valid & mem_req_ready;
  assign w_recv_fire  = (r_state == READ) & mem_rsp_valid;
  assign w_line_base  = r_addr & ~c_LINE_MASK;

  // Assembly buffer with the word that arrives in this cycle merged in. The
  // line response is taken from this value so the last word lands in the
  // same edge that enters RESP.
  always_comb begin
    w_line_next = r_line;
    if (w_recv_fire) begin
      w_line_next[int'(w_recv_idx) * WORD_WIDTH +: WORD_WIDTH] = mem_rsp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_line      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A write wins over a simultaneous read.
          if (n2m_request_write) begin
            r_addr      <= n2m_request_address;
            r_line      <= n2m_request_data;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= WRITE;
          end else if (n2m_request_read) begin
            r_addr      <= n2m_request_address;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_state     <= READ;
          end
        end

        WRITE: begin
          if (w_issue_fire) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
            if (r_issue_cnt == c_LAST) begin
              r_state <= IDLE;
            end
          end
        end

        READ: begin
          // Issue and receive run independently; a word may return in the
          // same cycle another is issued.
          if (w_issue_fire) begin
            r_issue_cnt <= r_issue_cnt + 1'b1;
          end
          r_line <= w_line_next;
          if (w_recv_fire) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
            if (r_recv_cnt == c_LAST) begin
              r_rsp_data <= w_line_next;
              r_rsp_addr <= r_addr;
              r_state    <= RESP;
            end
          end
        end

        RESP: begin
          if (mc_avail_o) begin
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low while reset is held, independent of the
  // state register's value before the first reset edge.
  assign m2n_request_available = ~reset & (r_state == IDLE);
  assign m2n_response_valid    = ~reset & (r_state == RESP) & mc_avail_o;
  assign m2n_response_address  = r_rsp_addr;
  assign m2n_response_data     = r_rsp_data;

  assign mem_req_valid   = ~reset & ((r_state == WRITE) |
                                     ((r_state == READ) & (r_issue_cnt < c_WORDS)));
  assign mem_req_write   = (r_state == WRITE);
  assign mem_req_address = w_line_base + (address_t'(w_issue_idx) * c_WORD_BYTES);
  assign mem_req_wdata   = r_line[int'(w_issue_idx) * WORD_WIDTH +: WORD_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_line_to_word_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_line_to_word_bridge                                          |
// | Purpose  : Self-checking bench for line_to_word_bridge. A word memory      |
// |            model serves the word port. A separate reference memory         |
// |            predicts line read contents and word write bursts.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_line_to_word_bridge;
  import line_to_word_bridge_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  address_t     n2m_request_address;
  dcache_line_t n2m_request_data;
  logic         n2m_request_read;
  logic         n2m_request_write;
  logic         mc_avail_o;
  logic         m2n_request_available;
  logic         m2n_response_valid;
  address_t     m2n_response_address;
  dcache_line_t m2n_response_data;
  logic         mem_req_valid;
  logic         mem_req_write;
  address_t     mem_req_address;
  logic [31:0]  mem_req_wdata;
  logic         mem_req_ready;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_rdata;

  line_to_word_bridge #(.WORD_WIDTH(32), .WORDS_PER_LINE(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .n2m_request_address   (n2m_request_address),
    .n2m_request_data      (n2m_request_data),
    .n2m_request_read      (n2m_request_read),
    .n2m_request_write     (n2m_request_write),
    .mc_avail_o            (mc_avail_o),
    .m2n_request_available (m2n_request_available),
    .m2n_response_valid    (m2n_response_valid),
    .m2n_response_address  (m2n_response_address),
    .m2n_response_data     (m2n_response_data),
    .mem_req_valid         (mem_req_valid),
    .mem_req_write         (mem_req_write),
    .mem_req_address       (mem_req_address),
    .mem_req_wdata         (mem_req_wdata),
    .mem_req_ready         (mem_req_ready),
    .mem_rsp_valid         (mem_rsp_valid),
    .mem_rsp_rdata         (mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int tog_base = 0;
  int ready_mode = 0;     // 0: always ready, 1: toggle from tog_base, 2: random
  bit lat_rand = 1'b0;    // 0: word returns one cycle after issue
  int n_rsp = 0;
  int n_reads = 0;
  int n_rd_issued = 0;
  int rd_delivered = 0;

  logic [63:0] wlog[$];
  logic [31:0] pend[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (m2n_response_valid === 1'b1) n_rsp++;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
  endfunction

  function automatic logic [31:0] dev_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Word memory: records accepted requests just before the edge that takes
  // them, returns read words in order after at least one cycle.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
        if (mem_req_write) begin
          wlog.push_back({mem_req_address, mem_req_wdata});
          mem[mem_req_address] = mem_req_wdata;
        end else begin
          pend.push_back(dev_word(mem_req_address));
          n_rd_issued++;
        end
      end
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = (((cyc - tog_base) % 2) == 0);
        default: mem_req_ready = ($urandom % 4) != 0;
      endcase
      if (pend.size() > 0 && (!lat_rand || ($urandom % 2) == 1)) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = pend.pop_front();
        rd_delivered++;
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
      end
    end
  end

  task automatic run_write(input address_t a, input dcache_line_t d, input int exp_lat, input bit both);
    address_t    base;
    int          n;
    int          rd0;
    int          rsp0;
    logic [63:0] e;
    base = a & ~32'h3F;
    next_cycle();
    wlog.delete();
    rd0  = n_rd_issued;
    rsp0 = n_rsp;
    n2m_request_address = a;
    n2m_request_data    = d;
    n2m_request_write   = 1'b1;
    n2m_request_read    = both;
    tog_base = cyc + 1;
    n = 0;
    do begin
      next_cycle();
      if (n == 0) begin
        n2m_request_write   = 1'b0;
        n2m_request_read    = 1'b0;
        n2m_request_address = $urandom;
        n2m_request_data    = {16{$urandom}};
      end
      n++;
      @(negedge clk);
    end while (m2n_request_available !== 1'b1 && n < 400);
    check_val("wr_done", n < 400, 1);
    if (exp_lat >= 0) check_val("wr_lat", n, exp_lat);
    check_val("wr_count", wlog.size(), 16);
    for (int i = 0; i < 16 && i < wlog.size(); i++) begin
      e = {base + 32'(4 * i), d[i*32 +: 32]};
      check_val($sformatf("wr_word%0d", i), wlog[i], e);
    end
    check_val("wr_no_reads", n_rd_issued - rd0, 0);
    check_val("wr_no_rsp", n_rsp - rsp0, 0);
    for (int i = 0; i < 16; i++) ref_mem[base + 32'(4 * i)] = d[i*32 +: 32];
  endtask

  task automatic run_read(input address_t a, input int exp_lat, input int hold, input bit intrude);
    address_t     base;
    dcache_line_t e;
    int           n;
    int           d0;
    base = a & ~32'h3F;
    for (int i = 0; i < 16; i++) e[i*32 +: 32] = ref_word(base + 32'(4 * i));
    next_cycle();
    d0 = rd_delivered;
    mc_avail_o          = (hold == 0);
    n2m_request_address = a;
    n2m_request_read    = 1'b1;
    n2m_request_write   = 1'b0;
    n = 0;
    do begin
      next_cycle();
      if (n == 0) begin
        n2m_request_read    = intrude;
        n2m_request_address = a ^ 32'h0000_1000;
      end
      if (n == 4) n2m_request_read = 1'b0;
      n++;
      @(negedge clk);
      if (intrude && n <= 4) check_val("rd_busy_avail", m2n_request_available, 0);
    end while (((hold == 0) ? (m2n_response_valid !== 1'b1) : (rd_delivered - d0 < 16)) && n < 400);
    check_val("rd_done", n < 400, 1);
    if (hold > 0) begin
      next_cycle();
      @(negedge clk);
      for (int k = 0; k < hold; k++) begin
        check_val("rd_hold_valid", m2n_response_valid, 0);
        check_val("rd_hold_avail", m2n_request_available, 0);
        next_cycle();
        if (k == hold - 1) mc_avail_o = 1'b1;
        @(negedge clk);
      end
    end else if (exp_lat >= 0) begin
      check_val("rd_lat", n, exp_lat);
    end
    check_val("rd_valid", m2n_response_valid, 1);
    check_val("rd_addr", m2n_response_address, a);
    check_val("rd_data", m2n_response_data, e);
    n_reads++;
    next_cycle();
    mc_avail_o = $urandom % 2;
    @(negedge clk);
    check_val("rd_pulse_end", m2n_response_valid, 0);
    check_val("rd_idle_avail", m2n_request_available, 1);
    check_val("rd_data_held", m2n_response_data, e);
  endtask

  task automatic run_reset_mid_read();
    int n;
    int i0;
    next_cycle();
    mc_avail_o = 1'b1;
    i0 = n_rd_issued;
    n2m_request_address = 32'h0000_0100;
    n2m_request_read    = 1'b1;
    n = 0;
    do begin
      next_cycle();
      n2m_request_read = 1'b0;
      n++;
      @(negedge clk);
      #1;
    end while (n_rd_issued - i0 < 7 && n < 100);
    check_val("rst_progress", n < 100, 1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_val("rst_avail_low", m2n_request_available, 0);
    check_val("rst_rsp_low", m2n_response_valid, 0);
    check_val("rst_memreq_low", mem_req_valid, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_avail_after", m2n_request_available, 1);
    check_val("rst_rsp_addr", m2n_response_address, 0);
    check_val("rst_rsp_data", m2n_response_data, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      check_val("rst_stale_avail", m2n_request_available, 1);
      check_val("rst_stale_memreq", mem_req_valid, 0);
      check_val("rst_stale_rsp", m2n_response_valid, 0);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    dcache_line_t d;
    address_t     a;
    reset               = 1'b1;
    n2m_request_address = '0;
    n2m_request_data    = '0;
    n2m_request_read    = 1'b0;
    n2m_request_write   = 1'b0;
    mc_avail_o          = 1'b1;

    @(negedge clk);
    check_val("reset_avail", m2n_request_available, 0);
    check_val("reset_rsp_valid", m2n_response_valid, 0);
    check_val("reset_memreq", mem_req_valid, 0);
    check_val("reset_rsp_addr", m2n_response_address, 0);
    check_val("reset_rsp_data", m2n_response_data, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_val("post_reset_avail", m2n_request_available, 1);

    // Directed line write, always-ready memory.
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = 32'h1000 + 32'(i);
    run_write(32'h0000_0040, d, 17, 1'b0);

    // Directed line read with known memory contents.
    for (int i = 0; i < 16; i++) begin
      mem[32'h80 + 32'(4 * i)]     = 32'hA0 + 32'(i);
      ref_mem[32'h80 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    run_read(32'h0000_0080, 18, 0, 1'b0);

    // Requester not ready for five cycles in RESP.
    run_read(32'h0000_0080, -1, 5, 1'b0);

    // Alternating ready during a write.
    ready_mode = 1;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    run_write(32'h0000_0200, d, 32, 1'b0);
    ready_mode = 0;

    // Read and write together is a write; read during READ is ignored.
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    run_write(32'h0000_0300, d, 17, 1'b1);
    run_read(32'h0000_0044, 18, 0, 1'b1);

    run_reset_mid_read();

    // Random mix over a small address range so reads hit earlier writes.
    for (int t = 0; t < 24; t++) begin
      ready_mode = $urandom_range(0, 2);
      lat_rand   = ($urandom % 2) == 1;
      a = $urandom & 32'h0000_01FF;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      if (($urandom % 2) == 1) run_write(a, d, -1, ($urandom % 2) == 1);
      else run_read(a, -1, (($urandom % 3) == 0) ? $urandom_range(1, 4) : 0, 1'b0);
    end

    next_cycle();
    next_cycle();
    check_val("rsp_pulse_total", n_rsp, n_reads);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
